wb_result_reporter: RTL
=======================

Name: wb_result_reporter

Overview:
- Parametrised replacement for the fixed register-watch reporting logic at the core top.
- Snoops the writeback port and captures writes to any register selected by a mask.
- Buffers captured writes in a FIFO and drains them to the peripheral interface over a valid/ready handshake.
- Supports a selectable full-FIFO policy and a saturating count of dropped results.

Parameters:
- CORE, 0: core id; driven onto to_peripheral_core.
- DATA_WIDTH, 32: writeback data width.
- REG_MASK, 32'h03FC0200: bit i set means writes to x[i] are reported; default selects x9 and x18-x25. Bit 0 is ignored.
- FIFO_DEPTH, 8: number of entries; must be a power of two, at least 2.
- PTR_BITS, 3: log2(FIFO_DEPTH).
- FULL_POLICY, 0: 0 drops the new write when full; 1 discards the oldest entry and keeps the new one.
- PORT_ID, 2'b00: value driven on to_peripheral.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: capture enable; draining continues while enable=0.
- write, input, 1: writeback register-write strobe.
- write_reg, input, 5: writeback destination register.
- write_data, input, DATA_WIDTH: writeback data.
- to_peripheral, output, 2: channel id; constant PORT_ID.
- to_peripheral_core, output, 2: CORE[1:0].
- to_peripheral_reg, output, 5: register number of the head entry.
- to_peripheral_data, output, DATA_WIDTH: data of the head entry.
- to_peripheral_valid, output, 1: head entry is valid.
- to_peripheral_ready, input, 1: peripheral accepts the head entry.
- fifo_count, output, PTR_BITS+1: current occupancy.
- drop_count, output, 16: saturating count of lost results.

Behaviour:
- Reset (reset=0, async):
  - read and write pointers clear to 0; fifo_count=0; drop_count=0.
  - to_peripheral_valid=0; to_peripheral_reg=0; to_peripheral_data=0.
  - Storage contents are don't-care.
  - A reset asserted mid-handshake discards all entries immediately.
- Capture condition, sampled on the rising edge: push = enable && write && (write_reg!=0) && REG_MASK[write_reg].
- Pop condition: pop = to_peripheral_valid && to_peripheral_ready.
- Latency: a write pushed at edge N gives to_peripheral_valid=1 in the cycle after edge N if the FIFO was empty. There is no combinational path from write to the outputs.
- Outputs:
  - to_peripheral_valid = (fifo_count!=0).
  - reg/data come from the head storage entry, i.e. register outputs through the read-pointer mux.
  - Data and reg must hold stable while valid=1 and ready=0.
- Handshake: the peripheral may hold ready=1 continuously, giving one pop per cycle. Valid never drops without a pop, except on reset.
- Pointers: both wrap modulo FIFO_DEPTH. fifo_count is updated by +1 (push only), -1 (pop only) or unchanged.
- Empty FIFO with push and no pop: entry stored; valid rises next cycle.
- Empty FIFO: pop is impossible (valid=0).
- Simultaneous push and pop, not full: both happen; count unchanged.
- Full FIFO (count=FIFO_DEPTH):
  - push with pop: both accepted; count stays FIFO_DEPTH; no drop.
  - push without pop, FULL_POLICY=0: new write discarded; drop_count+1.
  - push without pop, FULL_POLICY=1: head discarded (read pointer advances), new entry written at the write pointer; count unchanged; drop_count+1.
  - FULL_POLICY=1 while ready=0: head outputs may change; valid stays 1.
- drop_count saturates at 16'hFFFF and does not wrap.
- enable=0: no push; pops continue; drop_count unchanged.
- Ordering: entries leave strictly in push order, apart from oldest-discard under FULL_POLICY=1.

Test Plan:
- Reset, then write=1, write_reg=18, data=32'h1234 with ready=1: valid=1 next cycle with reg=18, data=32'h1234, port 0; popped; count returns to 0.
- Writes to x5, x0 and x26 with the default mask: no push; valid stays 0; drop_count=0.
- Depth 8, ready=0, 9 writes to x9 with data 1..9, FULL_POLICY=0: count=8, drop_count=1; after ready=1, data out is 1..8 in order.
- Same stimulus with FULL_POLICY=1: drop_count=1; drained data is 2..9.
- FIFO full, ready=1 and push in the same cycle: count stays 8, drop_count=0, order preserved; then ready held low for 3 cycles: head data is stable.
- Reset deasserted-then-asserted (reset=0) with 5 entries queued: valid=0, count=0 immediately; drop_count forced to 16'hFFFF plus one more drop stays 16'hFFFF.

Source files
------------

// File: rtl/wb_result_reporter.sv
// ============================================================================
// Module  : wb_result_reporter
// Brief   : Snoops writeback, buffers masked register writes in a FIFO and
//           drains them to the peripheral over a valid/ready handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_result_reporter #(
    parameter int          CORE        = 0,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] REG_MASK    = 32'h03FC0200,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          PTR_BITS    = 3,
    parameter int          FULL_POLICY = 0,
    parameter logic [1:0]  PORT_ID     = 2'b00
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  write,
    input  logic [4:0]            write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [1:0]            to_peripheral,
    output logic [1:0]            to_peripheral_core,
    output logic [4:0]            to_peripheral_reg,
    output logic [DATA_WIDTH-1:0] to_peripheral_data,
    output logic                  to_peripheral_valid,
    input  logic                  to_peripheral_ready,
    output logic [PTR_BITS:0]     fifo_count,
    output logic [15:0]           drop_count
);

    localparam logic [PTR_BITS:0] C_DEPTH   = (PTR_BITS+1)'(FIFO_DEPTH);
    localparam logic [1:0]        C_CORE    = 2'(CORE);
    localparam logic [15:0]       C_DROPMAX = 16'hFFFF;

    logic [4:0]            mem_reg  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];

    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]   count_q,  count_d;
    logic [15:0]         drop_q,   drop_d;

    logic w_push, w_pop, w_full, w_valid;
    logic w_do_write, w_do_read, w_drop;

    assign w_valid = (count_q != '0);
    assign w_full  = (count_q == C_DEPTH);
    assign w_push  = enable && write && (write_reg != 5'd0) && REG_MASK[write_reg];
    assign w_pop   = w_valid && to_peripheral_ready;

    // A push into a full FIFO with no pop is a loss; the oldest-discard policy
    // turns it into a write plus a forced read so the newest value survives.
    assign w_drop     = w_push && w_full && !w_pop;
    assign w_do_write = w_push && (!w_full || w_pop || (FULL_POLICY == 1));
    assign w_do_read  = w_pop || (w_drop && (FULL_POLICY == 1));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (w_do_write) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_do_read)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (w_do_write && !w_do_read)      count_d = count_q + 1'b1;
        else if (w_do_read && !w_do_write) count_d = count_q - 1'b1;
        if (w_drop && (drop_q != C_DROPMAX)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_write) begin
            mem_reg[wr_ptr_q]  <= write_reg;
            mem_data[wr_ptr_q] <= write_data;
        end
    end

    // Gated by valid so an empty FIFO presents zeros rather than stale storage.
    assign to_peripheral_reg   = w_valid ? mem_reg[rd_ptr_q]  : 5'd0;
    assign to_peripheral_data  = w_valid ? mem_data[rd_ptr_q] : '0;
    assign to_peripheral_valid = w_valid;
    assign to_peripheral       = PORT_ID;
    assign to_peripheral_core  = C_CORE;
    assign fifo_count          = count_q;
    assign drop_count          = drop_q;

endmodule

`default_nettype wire
